// File: rtl/munoc_burst_beat_gen_pkg.sv
// Shared definitions for the MUNOC burst beat generator: AXI field widths,
// burst codes, FSM state encoding and small constant helpers.
package munoc_burst_beat_gen_pkg;

    localparam int BW_AXI_ALEN   = 8;
    localparam int BW_AXI_ASIZE  = 3;
    localparam int BW_AXI_ABURST = 2;

    localparam logic [BW_AXI_ABURST-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [BW_AXI_ABURST-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [BW_AXI_ABURST-1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [BW_AXI_ABURST-1:0] AXI_BURST_RSVD  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } beat_state_t;

    // ceil(log2(nb)); with nb a power of two this is the largest legal size code
    function automatic int log2_nb(input int nb);
        int r;
        r = 0;
        while ((1 << r) < nb) r++;
        return r;
    endfunction

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats
    function automatic logic legal_wrap_len(input logic [BW_AXI_ALEN-1:0] len);
        return (len == BW_AXI_ALEN'(1)) || (len == BW_AXI_ALEN'(3)) ||
               (len == BW_AXI_ALEN'(7)) || (len == BW_AXI_ALEN'(15));
    endfunction

endpackage

// File: rtl/munoc_burst_beat_gen_cmd_queue.sv
// Small synchronous command FIFO holding {addr,len,size,burst}; the head entry
// is always visible on the outputs so the beat generator can load it directly.
module munoc_cmd_queue
    import munoc_burst_beat_gen_pkg::*;
#(
    parameter int BW_ADDR   = 32,
    parameter int CMD_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     i_push,
    input  logic [BW_ADDR-1:0]       i_addr,
    input  logic [BW_AXI_ALEN-1:0]   i_len,
    input  logic [BW_AXI_ASIZE-1:0]  i_size,
    input  logic [BW_AXI_ABURST-1:0] i_burst,
    input  logic                     i_pop,
    output logic [BW_ADDR-1:0]       o_addr,
    output logic [BW_AXI_ALEN-1:0]   o_len,
    output logic [BW_AXI_ASIZE-1:0]  o_size,
    output logic [BW_AXI_ABURST-1:0] o_burst,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int BW_ENTRY = BW_ADDR + BW_AXI_ALEN + BW_AXI_ASIZE + BW_AXI_ABURST;
    localparam int PW       = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW       = $clog2(CMD_DEPTH + 1);

    logic [BW_ENTRY-1:0] r_mem [CMD_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(CMD_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage needs no reset: occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= {i_addr, i_len, i_size, i_burst};
    end

    // Pointer and occupancy bookkeeping; the caller never pushes when full or pops when empty
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign {o_addr, o_len, o_size, o_burst} = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(CMD_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/munoc_burst_beat_gen.sv
// AXI burst beat generator: queues AR/AW-style commands and expands each one
// into len+1 registered beat records (address, index, last, strobe, error).
module munoc_burst_beat_gen
    import munoc_burst_beat_gen_pkg::*;
#(
    parameter int BW_ADDR   = 32,
    parameter int BW_DATA   = 64,
    parameter int CMD_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [BW_ADDR-1:0]       cmd_addr,
    input  logic [BW_AXI_ALEN-1:0]   cmd_len,
    input  logic [BW_AXI_ASIZE-1:0]  cmd_size,
    input  logic [BW_AXI_ABURST-1:0] cmd_burst,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [BW_ADDR-1:0]       beat_addr,
    output logic [BW_AXI_ALEN-1:0]   beat_index,
    output logic                     beat_last,
    output logic [BW_DATA/8-1:0]     beat_strb,
    output logic                     beat_err,
    output logic                     idle
);

    localparam int NB = BW_DATA / 8;
    localparam int LOG2_NB = log2_nb(NB);
    localparam logic [BW_AXI_ASIZE-1:0] MAX_SIZE  = BW_AXI_ASIZE'(LOG2_NB);
    localparam logic [BW_ADDR-1:0]      LANE_MASK = BW_ADDR'(NB - 1);

    // FSM and active-burst registers
    beat_state_t               r_state;
    beat_state_t               w_state_next;
    logic [BW_ADDR-1:0]        r_beat_addr;
    logic [BW_AXI_ALEN-1:0]    r_beat_index;
    logic                      r_beat_last;
    logic [NB-1:0]             r_beat_strb;
    logic                      r_beat_err;
    logic [BW_AXI_ALEN-1:0]    r_len;
    logic [BW_AXI_ASIZE-1:0]   r_size;
    logic [BW_AXI_ABURST-1:0]  r_burst;
    logic [BW_ADDR-1:0]        r_wmask;

    // Queue interface
    logic                      w_q_full;
    logic                      w_q_empty;
    logic [BW_ADDR-1:0]        w_q_addr;
    logic [BW_AXI_ALEN-1:0]    w_q_len;
    logic [BW_AXI_ASIZE-1:0]   w_q_size;
    logic [BW_AXI_ABURST-1:0]  w_q_burst;
    logic                      w_push;
    logic                      w_pop;

    // Control
    logic                      w_cmd_fire;
    logic                      w_beat_fire;
    logic                      w_slot_free;
    logic                      w_load;
    logic                      w_bypass;
    logic                      w_advance;

    // Command being loaded: queue head, or the live command when the queue is empty
    logic [BW_ADDR-1:0]        w_src_addr;
    logic [BW_AXI_ALEN-1:0]    w_src_len;
    logic [BW_AXI_ASIZE-1:0]   w_src_size;
    logic [BW_AXI_ABURST-1:0]  w_src_burst;
    logic [BW_ADDR-1:0]        w_src_bytes;
    logic [BW_ADDR-1:0]        w_src_align;
    logic [BW_ADDR-1:0]        w_src_wmask;
    logic                      w_src_err;
    logic [NB-1:0]             w_src_strb;

    // Next beat of the active burst
    logic [BW_ADDR-1:0]        w_cur_bytes;
    logic [BW_ADDR-1:0]        w_cur_align;
    logic [BW_ADDR-1:0]        w_cur_incr;
    logic [BW_ADDR-1:0]        w_next_addr;
    logic [BW_ADDR-1:0]        w_next_align;
    logic [NB-1:0]             w_next_strb;

    munoc_cmd_queue #(
        .BW_ADDR   (BW_ADDR),
        .CMD_DEPTH (CMD_DEPTH)
    ) u_cmd_queue (
        .clk     (clk),
        .rstnn   (rstnn),
        .i_push  (w_push),
        .i_addr  (cmd_addr),
        .i_len   (cmd_len),
        .i_size  (cmd_size),
        .i_burst (cmd_burst),
        .i_pop   (w_pop),
        .o_addr  (w_q_addr),
        .o_len   (w_q_len),
        .o_size  (w_q_size),
        .o_burst (w_q_burst),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign cmd_ready   = ~w_q_full;
    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign w_beat_fire = beat_valid & beat_ready;
    // A command taken while nothing is queued skips the FIFO only if it loads now
    assign w_push      = w_cmd_fire & ~w_bypass;

    assign w_src_addr  = w_q_empty ? cmd_addr  : w_q_addr;
    assign w_src_len   = w_q_empty ? cmd_len   : w_q_len;
    assign w_src_size  = w_q_empty ? cmd_size  : w_q_size;
    assign w_src_burst = w_q_empty ? cmd_burst : w_q_burst;

    assign w_src_bytes = BW_ADDR'(1) << w_src_size;
    assign w_src_align = w_src_addr & ~(w_src_bytes - BW_ADDR'(1));
    assign w_src_wmask = ((BW_ADDR'(w_src_len) + BW_ADDR'(1)) << w_src_size) - BW_ADDR'(1);
    assign w_src_err   = (w_src_size > MAX_SIZE) ||
                         (w_src_burst == AXI_BURST_RSVD) ||
                         ((w_src_burst == AXI_BURST_WRAP) &&
                          (!legal_wrap_len(w_src_len) ||
                           ((w_src_addr & (w_src_bytes - BW_ADDR'(1))) != '0)));

    assign w_cur_bytes  = BW_ADDR'(1) << r_size;
    assign w_cur_align  = r_beat_addr & ~(w_cur_bytes - BW_ADDR'(1));
    assign w_cur_incr   = w_cur_align + w_cur_bytes;
    assign w_next_align = w_next_addr & ~(w_cur_bytes - BW_ADDR'(1));

    // Next-beat address; erroneous bursts walk like INCR
    always_comb begin
        w_next_addr = w_cur_incr;
        if (!r_beat_err) begin
            case (r_burst)
                AXI_BURST_FIXED: w_next_addr = r_beat_addr;
                AXI_BURST_WRAP:  w_next_addr = (r_beat_addr & ~r_wmask) | (w_cur_incr & r_wmask);
                default:         w_next_addr = w_cur_incr;
            endcase
        end
    end

    // Per-lane strobe: lanes from the address offset up to the end of the size container
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign w_src_strb[gi]  = (BW_ADDR'(gi) >= (w_src_addr & LANE_MASK)) &&
                                     (BW_ADDR'(gi) <= (w_src_align & LANE_MASK) + w_src_bytes - BW_ADDR'(1));
            assign w_next_strb[gi] = (BW_ADDR'(gi) >= (w_next_addr & LANE_MASK)) &&
                                     (BW_ADDR'(gi) <= (w_next_align & LANE_MASK) + w_cur_bytes - BW_ADDR'(1));
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state: a free slot (idle, or last beat leaving) loads queue head, else bypasses a live command
    always_comb begin
        w_state_next = r_state;
        w_slot_free  = 1'b0;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        w_bypass     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: w_slot_free = 1'b1;
            ST_BURST: begin
                if (w_beat_fire) begin
                    if (r_beat_last) w_slot_free = 1'b1;
                    else             w_advance   = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_slot_free) begin
            if (!w_q_empty) begin
                w_load       = 1'b1;
                w_pop        = 1'b1;
                w_state_next = ST_BURST;
            end else if (w_cmd_fire) begin
                w_load       = 1'b1;
                w_bypass     = 1'b1;
                w_state_next = ST_BURST;
            end else begin
                w_state_next = ST_IDLE;
            end
        end
    end

    // Beat record and burst context: load a new command or step to the next beat
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_beat_addr  <= '0;
            r_beat_index <= '0;
            r_beat_last  <= 1'b0;
            r_beat_strb  <= '0;
            r_beat_err   <= 1'b0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_wmask      <= '0;
        end else if (w_load) begin
            r_beat_addr  <= w_src_addr;
            r_beat_index <= '0;
            r_beat_last  <= (w_src_len == '0);
            r_beat_strb  <= w_src_err ? '0 : w_src_strb;
            r_beat_err   <= w_src_err;
            r_len        <= w_src_len;
            r_size       <= w_src_size;
            r_burst      <= w_src_burst;
            r_wmask      <= w_src_wmask;
        end else if (w_advance) begin
            r_beat_addr  <= w_next_addr;
            r_beat_index <= r_beat_index + BW_AXI_ALEN'(1);
            r_beat_last  <= ((r_beat_index + BW_AXI_ALEN'(1)) == r_len);
            // FIXED keeps the first-beat strobe, errors keep all lanes off
            if (r_beat_err)                     r_beat_strb <= '0;
            else if (r_burst != AXI_BURST_FIXED) r_beat_strb <= w_next_strb;
        end
    end

    assign beat_valid = (r_state == ST_BURST);
    assign beat_addr  = r_beat_addr;
    assign beat_index = r_beat_index;
    assign beat_last  = r_beat_last;
    assign beat_strb  = r_beat_strb;
    assign beat_err   = r_beat_err;
    assign idle       = (r_state == ST_IDLE) && w_q_empty;

endmodule

// File: tb/tb_munoc_burst_beat_gen.sv
// Self-checking bench: directed cases plus randomized commands and beat_ready,
// checked every cycle against a command-level reference model.
module tb_munoc_burst_beat_gen;
    import munoc_burst_beat_gen_pkg::*;

    localparam int BW_ADDR   = 32;
    localparam int BW_DATA   = 64;
    localparam int CMD_DEPTH = 2;
    localparam int NB        = BW_DATA / 8;
    localparam int LOG2_NB   = 3;

    logic                     clk = 1'b0;
    logic                     rstnn;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [BW_ADDR-1:0]       cmd_addr;
    logic [BW_AXI_ALEN-1:0]   cmd_len;
    logic [BW_AXI_ASIZE-1:0]  cmd_size;
    logic [BW_AXI_ABURST-1:0] cmd_burst;
    logic                     beat_valid;
    logic                     beat_ready;
    logic [BW_ADDR-1:0]       beat_addr;
    logic [BW_AXI_ALEN-1:0]   beat_index;
    logic                     beat_last;
    logic [NB-1:0]            beat_strb;
    logic                     beat_err;
    logic                     idle;

    munoc_burst_beat_gen #(
        .BW_ADDR   (BW_ADDR),
        .BW_DATA   (BW_DATA),
        .CMD_DEPTH (CMD_DEPTH)
    ) dut (
        .clk        (clk),
        .rstnn      (rstnn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_index (beat_index),
        .beat_last  (beat_last),
        .beat_strb  (beat_strb),
        .beat_err   (beat_err),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic [7:0]    idx;
        logic          last;
        logic [NB-1:0] strb;
        logic          err;
    } beat_t;

    beat_t         exp_q[$];
    logic [31:0]   obs_addr[$];
    logic [NB-1:0] obs_strb[$];
    logic          obs_last[$];
    int            n_out   = 0;
    int            err_cnt = 0;
    int            chk_cnt = 0;
    logic          rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Lanes from a%NB up to the end of the B-byte container holding a
    function automatic logic [NB-1:0] lanes(input longint unsigned a, input longint unsigned b);
        logic [NB-1:0]   s;
        longint unsigned lo, hi;
        lo = a % NB;
        hi = ((a & ~(b - 1)) % NB) + b - 1;
        for (int i = 0; i < NB; i++) s[i] = (i >= lo) && (i <= hi);
        return s;
    endfunction

    // Expand a command into its expected beats using the burst rules directly
    task automatic expand(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        longint unsigned b, a0, w, cur;
        logic            e;
        beat_t           bt;
        b   = 64'd1 << size;
        a0  = {32'd0, addr} & ~(b - 1);
        w   = (longint'(len) + 1) * b;
        e   = (size > LOG2_NB) || (burst == 2'd3) ||
              ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
              ((burst == 2'd2) && (({32'd0, addr} % b) != 0));
        cur = {32'd0, addr};
        for (int k = 0; k <= int'(len); k++) begin
            if (k > 0) begin
                if (e || burst == 2'd1)  cur = (a0 + longint'(k) * b) & 64'hFFFF_FFFF;
                else if (burst == 2'd0)  cur = {32'd0, addr};
                else                     cur = (cur & ~(w - 1)) | ((cur + b) & (w - 1));
            end
            bt.addr = cur[31:0];
            bt.idx  = 8'(k);
            bt.last = (k == int'(len));
            bt.err  = e;
            bt.strb = e ? '0 : lanes(cur, b);
            exp_q.push_back(bt);
        end
    endtask

    // Per-cycle monitor: compare handshake-level outputs, score beats, update the model
    initial begin
        beat_t bt;
        forever begin
            @(negedge clk);
            if (!rstnn) begin
                exp_q.delete();
                n_out = 0;
            end else begin
                chk("cmd_ready", cmd_ready, (((n_out > 0) ? n_out - 1 : 0) < CMD_DEPTH));
                chk("beat_valid", beat_valid, (n_out > 0));
                chk("idle", idle, (n_out == 0));
                if (beat_valid && beat_ready) begin
                    $display("beat addr=%08h idx=%0d last=%0b strb=%02h err=%0b",
                             beat_addr, beat_index, beat_last, beat_strb, beat_err);
                    obs_addr.push_back(beat_addr);
                    obs_strb.push_back(beat_strb);
                    obs_last.push_back(beat_last);
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", beat_valid, 1'b0);
                    end else begin
                        bt = exp_q.pop_front();
                        chk("beat_addr",  beat_addr,  bt.addr);
                        chk("beat_index", beat_index, bt.idx);
                        chk("beat_last",  beat_last,  bt.last);
                        chk("beat_strb",  beat_strb,  bt.strb);
                        chk("beat_err",   beat_err,   bt.err);
                        if (bt.last) n_out--;
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    $display("cmd addr=%08h len=%0d size=%0d burst=%0d",
                             cmd_addr, cmd_len, cmd_size, cmd_burst);
                    expand(cmd_addr, cmd_len, cmd_size, cmd_burst);
                    n_out++;
                end
            end
        end
    end

    // Random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) beat_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Offer a command and hold it until accepted (bounded)
    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("cmd_accept_timeout", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (idle) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", idle, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_strb.delete();
        obs_last.delete();
    endtask

    initial begin
        logic [31:0]   t1_addr [4];
        logic [NB-1:0] t1_strb [4];
        logic [31:0]   t2_addr [4];
        logic [7:0]    wl [4];
        logic [31:0]   ra;
        logic [7:0]    rl;
        logic [2:0]    rs;
        logic [1:0]    rb;

        t1_addr = '{32'h1003, 32'h1004, 32'h1008, 32'h100C};
        t1_strb = '{8'h08, 8'hF0, 8'h0F, 8'hF0};
        t2_addr = '{32'h2038, 32'h2020, 32'h2028, 32'h2030};
        wl      = '{8'd1, 8'd3, 8'd7, 8'd15};

        rstnn      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        cmd_burst  = '0;
        beat_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_beat_valid", beat_valid, 1'b0);
        chk("rst_beat_addr",  beat_addr,  32'h0);
        chk("rst_beat_index", beat_index, 8'h0);
        chk("rst_beat_last",  beat_last,  1'b0);
        chk("rst_beat_strb",  beat_strb,  8'h0);
        chk("rst_beat_err",   beat_err,   1'b0);
        chk("rst_idle",       idle,       1'b1);
        chk("rst_cmd_ready",  cmd_ready,  1'b1);
        rstnn = 1'b1;
        @(posedge clk);
        #1;

        // Unaligned narrow INCR
        beat_ready = 1'b1;
        clear_obs();
        send_cmd(32'h1003, 8'd3, 3'd2, AXI_BURST_INCR);
        wait_idle();
        chk("incr_count", obs_addr.size(), 4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            chk("incr_addr_tbl", obs_addr[i], t1_addr[i]);
            chk("incr_strb_tbl", obs_strb[i], t1_strb[i]);
            chk("incr_last_tbl", obs_last[i], (i == 3));
        end

        // WRAP across the 32-byte window
        clear_obs();
        send_cmd(32'h2038, 8'd3, 3'd3, AXI_BURST_WRAP);
        wait_idle();
        chk("wrap_count", obs_addr.size(), 4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            chk("wrap_addr_tbl", obs_addr[i], t2_addr[i]);
            chk("wrap_strb_tbl", obs_strb[i], 8'hFF);
        end

        // FIXED repeats address and strobe
        clear_obs();
        send_cmd(32'h40, 8'd2, 3'd1, AXI_BURST_FIXED);
        wait_idle();
        chk("fixed_count", obs_addr.size(), 3);
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
            chk("fixed_addr_tbl", obs_addr[i], 32'h40);
            chk("fixed_strb_tbl", obs_strb[i], 8'h03);
        end

        // Back-to-back bursts: the per-cycle model catches any bubble or early idle
        send_cmd(32'h3000, 8'd1, 3'd3, AXI_BURST_INCR);
        send_cmd(32'h3100, 8'd1, 3'd3, AXI_BURST_INCR);
        wait_idle();

        // Backpressure: CMD_DEPTH+1 fit, the next waits until beats drain
        beat_ready = 1'b0;
        for (int i = 0; i < CMD_DEPTH + 1; i++)
            send_cmd(32'h4000 + 32'(i) * 32'h100, 8'd2, 3'd3, AXI_BURST_INCR);
        @(negedge clk);
        chk("full_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                beat_ready = 1'b1;
            end
            send_cmd(32'h4800, 8'd0, 3'd3, AXI_BURST_INCR);
        join
        wait_idle();

        // Illegal commands: bad WRAP length, oversize beat
        send_cmd(32'h5000, 8'd2, 3'd3, AXI_BURST_WRAP);
        send_cmd(32'h5100, 8'd3, 3'd4, AXI_BURST_INCR);
        wait_idle();

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            rb = 2'($urandom_range(0, 3));
            rs = 3'($urandom_range(0, LOG2_NB));
            if ($urandom_range(0, 9) == 0) rs = 3'($urandom_range(0, 7));
            if (rb == AXI_BURST_WRAP && $urandom_range(0, 4) != 0) rl = wl[$urandom_range(0, 3)];
            else                                                   rl = 8'($urandom_range(0, 15));
            ra = $urandom;
            if (rb == AXI_BURST_WRAP && $urandom_range(0, 4) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
            send_cmd(ra, rl, rs, rb);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        #1;
        beat_ready = 1'b1;
        wait_idle();
        chk("exp_q_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a burst with a full queue
        beat_ready = 1'b0;
        for (int i = 0; i < CMD_DEPTH + 1; i++)
            send_cmd(32'h6000 + 32'(i) * 32'h200, 8'd20, 3'd3, AXI_BURST_INCR);
        beat_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rstnn = 1'b0;
        #1;
        chk("arst_beat_valid", beat_valid, 1'b0);
        chk("arst_idle",       idle,       1'b1);
        chk("arst_cmd_ready",  cmd_ready,  1'b1);
        repeat (2) @(posedge clk);
        #1;
        rstnn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_cmd(32'h7004, 8'd1, 3'd2, AXI_BURST_INCR);
        wait_idle();
        chk("exp_q_final", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
